dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, read-allocate data cache controller between the EX/MEM stage and main memory.
- Produces the `mem_ready` stall signal that every pipeline register gates its update with.
- Pipeline registers freeze while `mem_ready` is low. This block owns the other end of that handshake: when to stall, and for how long.
- Line size is 4 words. Refills are 4 single-word memory transactions.

---
 rtl/dcache_ctrl.sv | 144 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate data cache controller.
// Owns the mem_ready stall handshake between the MEM stage and main memory.
module dcache_ctrl #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int TAG_BITS = 32 - INDEX_BITS - 4;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [LINES-1:0]      r_valid;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [3:0][31:0]      r_data [LINES];
   logic [1:0]            r_cnt;
   logic                  r_memReq;
   logic                  r_memWe;
   logic [31:0]           r_memAddr;
   logic [31:0]           r_memWdata;

   logic [1:0]            w_offset;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic                  w_hit;
   logic                  w_ack;
   logic                  w_refillLast;
   logic                  w_unused;

   assign w_offset     = cpu_addr[3:2];
   assign w_index      = cpu_addr[INDEX_BITS+3:4];
   assign w_tag        = cpu_addr[31:INDEX_BITS+4];
   assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_ack        = mem_ack & r_memReq;
   assign w_refillLast = (r_state == REFILL) && w_ack && (r_cnt == 2'd3);
   assign w_unused     = ^cpu_addr[1:0];

   assign cpu_rdata = r_data[w_index][w_offset];
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // A store wins over a load when both are asserted; only a read hit or no access avoids a stall.
   always_comb begin
      w_nextState = r_state;
      mem_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_wr)                w_nextState = WRITE;
            else if (cpu_rd && !w_hit) w_nextState = REFILL;
            else                       mem_ready   = 1'b1;
         end
         REFILL: if (w_refillLast) w_nextState = DONE;
         WRITE:  if (w_ack)        w_nextState = DONE;
         DONE: begin
            mem_ready   = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Memory-side request registers; they hold steady until the matching ack arrives.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt      <= 2'd0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= 32'd0;
         r_memWdata <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cpu_wr) begin
                  r_memReq   <= 1'b1;
                  r_memWe    <= 1'b1;
                  r_memAddr  <= {cpu_addr[31:2], 2'b00};
                  r_memWdata <= cpu_wdata;
               end else if (cpu_rd && !w_hit) begin
                  r_cnt     <= 2'd0;
                  r_memReq  <= 1'b1;
                  r_memWe   <= 1'b0;
                  r_memAddr <= {cpu_addr[31:4], 4'b0000};
               end
            end
            REFILL: begin
               if (w_ack) begin
                  if (r_cnt != 2'd3) begin
                     r_cnt          <= r_cnt + 2'd1;
                     r_memAddr[3:2] <= r_cnt + 2'd1;
                  end else begin
                     r_memReq <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (w_ack) begin
                  r_memReq <= 1'b0;
                  r_memWe  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)             r_valid          <= '0;
      else if (w_refillLast) r_valid[w_index] <= 1'b1;
   end

   // Tag and data arrays carry no reset; a line only becomes visible once its valid bit is set.
   always_ff @(posedge clock) begin
      if ((r_state == REFILL) && w_ack) begin
         r_data[w_index][r_cnt] <= mem_rdata;
         if (r_cnt == 2'd3) r_tag[w_index] <= w_tag;
      end else if ((r_state == WRITE) && w_ack && w_hit) begin
         r_data[w_index][w_offset] <= cpu_wdata;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed plan, then random accesses against
// a line-level cache model and a word-addressed memory responder.
module tb_dcache_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        mem_ready, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          delay;
   } txn_t;

   txn_t        reqLog [$];
   logic [31:0] memStore [logic [31:0]];
   int          fixedDelay = 2;
   bit          spurious   = 1'b0;
   int          rspCnt     = 0;
   int          rspTarget  = 0;
   int          checkCount = 0;
   int          errCount   = 0;

   bit          refValid [64];
   logic [21:0] refTag   [64];
   logic [31:0] refData  [64][4];

   dcache_ctrl #(.INDEX_BITS(6)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial forever #5 clock = ~clock;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (memStore.exists(a)) return memStore[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Memory responder: acks each request after 1..3 cycles, logging every completed transaction.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clock);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (reset) begin
            rspCnt = 0;
         end else if (mem_req) begin
            if (rspCnt == 0) rspTarget = (fixedDelay != 0) ? fixedDelay : int'($urandom_range(1, 3));
            rspCnt++;
            if (rspCnt == rspTarget) begin
               mem_ack = 1'b1;
               rspCnt  = 0;
               if (mem_we) memStore[mem_addr] = mem_wdata;
               else        mem_rdata = memWord(mem_addr);
               reqLog.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata, rspTarget});
            end
         end else if (spurious && ($urandom_range(0, 3) == 0)) begin
            mem_ack = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One CPU access held until the cache releases the pipeline, checked against the model.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      int          idx, off, cycles, expCycles;
      logic [21:0] tg;
      bit          hit;
      logic [31:0] base;
      idx  = int'(addr[9:4]);
      off  = int'(addr[3:2]);
      tg   = addr[31:10];
      hit  = refValid[idx] && (refTag[idx] == tg);
      base = {addr[31:4], 4'h0};
      @(negedge clock);
      #1;
      cpu_rd    = rd;
      cpu_wr    = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      reqLog.delete();
      #1;
      if (!rd && !wr) begin
         checkOutput("idleReady", {31'd0, mem_ready}, 32'd1);
         checkOutput("idleNoReq", {31'd0, mem_req}, 32'd0);
      end else if (!wr && hit) begin
         checkOutput("hitReady", {31'd0, mem_ready}, 32'd1);
         checkOutput("hitData", cpu_rdata, refData[idx][off]);
         checkOutput("hitNoReq", {31'd0, mem_req}, 32'd0);
      end else begin
         checkOutput("stallStart", {31'd0, mem_ready}, 32'd0);
         cycles = 0;
         while (mem_ready !== 1'b1 && cycles < 100) begin
            @(negedge clock);
            #2;
            cycles++;
            if (cycles == 1) begin
               checkOutput("reqIssued", {31'd0, mem_req}, 32'd1);
               checkOutput("reqWe", {31'd0, mem_we}, {31'd0, wr});
               checkOutput("reqAddr", mem_addr, wr ? {addr[31:2], 2'b00} : base);
               if (wr) checkOutput("reqWdata", mem_wdata, wdata);
            end
         end
         checkOutput("doneReached", {31'd0, mem_ready}, 32'd1);
         expCycles = 1;
         foreach (reqLog[k]) expCycles += reqLog[k].delay;
         checkOutput("latency", 32'(cycles), 32'(expCycles));
         if (wr) begin
            checkOutput("writeTxns", 32'(reqLog.size()), 32'd1);
            if (reqLog.size() > 0) begin
               checkOutput("writeTxnAddr", reqLog[0].addr, {addr[31:2], 2'b00});
               checkOutput("writeTxnData", reqLog[0].data, wdata);
            end
            if (hit) refData[idx][off] = wdata;
         end else begin
            checkOutput("refillTxns", 32'(reqLog.size()), 32'd4);
            for (int k = 0; k < 4 && k < reqLog.size(); k++) begin
               checkOutput("refillAddr", reqLog[k].addr, base + 32'(4 * k));
               checkOutput("refillWe", {31'd0, reqLog[k].we}, 32'd0);
            end
            for (int k = 0; k < 4; k++) refData[idx][k] = memWord(base + 32'(4 * k));
            refValid[idx] = 1'b1;
            refTag[idx]   = tg;
            checkOutput("missData", cpu_rdata, refData[idx][off]);
         end
      end
      @(posedge clock);
      #1;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
   endtask

   initial begin
      int          cycles, kind;
      logic [31:0] addr;
      reset     = 1'b1;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      foreach (refValid[i]) refValid[i] = 1'b0;

      repeat (2) @(negedge clock);
      #2;
      checkOutput("resetReq", {31'd0, mem_req}, 32'd0);
      checkOutput("resetWe", {31'd0, mem_we}, 32'd0);
      checkOutput("resetAddr", mem_addr, 32'd0);
      checkOutput("resetWdata", mem_wdata, 32'd0);
      checkOutput("resetReady", {31'd0, mem_ready}, 32'd1);
      reset = 1'b0;

      fixedDelay = 2;
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_004C, 32'd0);

      fixedDelay = 1;
      applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0440, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D);
      applyStimulus(1'b0, 1'b0, 32'h0000_0000, 32'd0);

      // Reset in the middle of a refill, after two words have been accepted.
      fixedDelay = 2;
      @(negedge clock);
      #1;
      cpu_rd   = 1'b1;
      cpu_addr = 32'h0000_0080;
      reqLog.delete();
      cycles = 0;
      while (reqLog.size() < 2 && cycles < 100) begin
         @(negedge clock);
         #2;
         cycles++;
      end
      checkOutput("twoAcksSeen", {31'd0, reqLog.size() >= 2}, 32'd1);
      @(posedge clock);
      #1;
      checkOutput("reqBeforeReset", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("asyncReqClear", {31'd0, mem_req}, 32'd0);
      checkOutput("asyncAddrClear", mem_addr, 32'd0);
      foreach (refValid[i]) refValid[i] = 1'b0;
      @(negedge clock);
      cpu_rd = 1'b0;
      @(negedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_008C, 32'd0);

      // Random mix over a few tags and indices so hits, conflicts and write misses all occur.
      fixedDelay = 0;
      spurious   = 1'b1;
      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom_range(0, 9));
         addr = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if (kind == 0)     applyStimulus(1'b0, 1'b0, addr, 32'd0);
         else if (kind < 4) applyStimulus(1'b0, 1'b1, addr, $urandom);
         else               applyStimulus(1'b1, 1'b0, addr, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
      $finish;
   end

endmodule
